// File: rtl/fpq_led_pkg.sv
// rtl/fpq_led_pkg.sv - mode/speed encodings and seed helper for the LED pattern engine
package fpq_led_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L   = 2'b00,
    MODE_ROT_R   = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SPEED_X1 = 2'b00,
    SPEED_X2 = 2'b01,
    SPEED_X4 = 2'b10,
    SPEED_X8 = 2'b11
  } speed_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Widest LED bank the seed helper can describe; callers truncate to their width.
  localparam int LED_MAX = 64;

  // Pattern loaded when the engine switches into mode m on an n-LED bank.
  function automatic logic [LED_MAX-1:0] seed_of(input logic [1:0] m, input int n);
    logic [LED_MAX-1:0] s;
    s = '0;
    case (m)
      MODE_ROT_R:   s = {{(LED_MAX-1){1'b0}}, 1'b1} << (n - 1);
      MODE_JOHNSON: s = '0;
      default:      s = {{(LED_MAX-1){1'b0}}, 1'b1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fpq_tick_gen.sv
// rtl/fpq_tick_gen.sv - enabled counter with programmable terminal compare
module fpq_tick_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt;

  // >= rather than == so a limit lowered below the running count wraps on the next enabled cycle.
  assign hit = en && (cnt >= limit);

  // Count enabled cycles, wrap to zero on the terminal cycle, hold while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hit) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fpq_ledn_pattern.sv
// rtl/fpq_ledn_pattern.sv - N-LED pattern engine with free-running tick output (bounce mode under LEDPAT_BOUNCE_EN)
module fpq_ledn_pattern #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int N_LED   = 8
) (
  input  logic             clk_50mhz,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic             clk_1hz,
  output logic             step,
  output logic [N_LED-1:0] led
);

  import fpq_led_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;
  // One extra bit so DIV itself is representable before it is shifted by speed.
  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_W    = CW'(DIV);
  localparam logic [CW-1:0] HALF_LIM = CW'(DIV / 2 - 1);

  logic             half_hit;
  logic             step_hit;
  logic [CW-1:0]    step_lim;
  logic [1:0]       mode_eff;
  logic [1:0]       mode_q;
  logic [1:0]       mode_nxt;
  logic [N_LED-1:0] led_seed;
  logic [N_LED-1:0] led_nxt;

  assign step_lim = (DIV_W >> speed) - CW'(1);
  assign led_seed = N_LED'(seed_of(mode_eff, N_LED));

`ifdef LEDPAT_BOUNCE_EN
  logic dir_q;
  logic dir_nxt;
  assign mode_eff = mode;
`else
  // Without bounce support, 10 behaves exactly like rotate-left, so 00<->10 is not a mode change.
  assign mode_eff = (mode == MODE_BOUNCE) ? MODE_ROT_L : mode;
`endif

  fpq_tick_gen #(.W(CW)) u_half_tick (
    .clk   (clk_50mhz),
    .rst_n (rst_n),
    .en    (1'b1),
    .limit (HALF_LIM),
    .hit   (half_hit)
  );

  fpq_tick_gen #(.W(CW)) u_step_tick (
    .clk   (clk_50mhz),
    .rst_n (rst_n),
    .en    (start),
    .limit (step_lim),
    .hit   (step_hit)
  );

  // Square wave toggles every half period regardless of run state.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_1hz <= 1'b0;
    end else if (half_hit) begin
      clk_1hz <= ~clk_1hz;
    end
  end

  // Next pattern: reseed on a mode change, otherwise advance according to the held mode.
  always_comb begin
    led_nxt  = led;
    mode_nxt = mode_q;
`ifdef LEDPAT_BOUNCE_EN
    dir_nxt  = dir_q;
`endif
    if (step_hit) begin
      if (mode_eff != mode_q) begin
        led_nxt  = led_seed;
        mode_nxt = mode_eff;
`ifdef LEDPAT_BOUNCE_EN
        dir_nxt  = DIR_LEFT;
`endif
      end else begin
        case (mode_q)
          MODE_ROT_R:   led_nxt = {led[0], led[N_LED-1:1]};
          MODE_JOHNSON: led_nxt = {led[N_LED-2:0], ~led[N_LED-1]};
`ifdef LEDPAT_BOUNCE_EN
          MODE_BOUNCE: begin
            // Turn around on the end bit within the same step so each end is lit only once.
            if (dir_q == DIR_LEFT) begin
              if (led[N_LED-1]) begin
                dir_nxt = DIR_RIGHT;
                led_nxt = led >> 1;
              end else begin
                led_nxt = led << 1;
              end
            end else begin
              if (led[0]) begin
                dir_nxt = DIR_LEFT;
                led_nxt = led << 1;
              end else begin
                led_nxt = led >> 1;
              end
            end
          end
`endif
          default:      led_nxt = {led[N_LED-2:0], led[N_LED-1]};
        endcase
      end
    end
  end

  // Pattern, held mode and step pulse all update on the terminal edge together.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      led    <= N_LED'(1);
      mode_q <= MODE_ROT_L;
      step   <= 1'b0;
    end else begin
      led    <= led_nxt;
      mode_q <= mode_nxt;
      step   <= step_hit;
    end
  end

`ifdef LEDPAT_BOUNCE_EN
  // Bounce direction register.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_LEFT;
    end else begin
      dir_q <= dir_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fpq_ledn_pattern.sv
// tb/tb_fpq_ledn_pattern.sv - directed bench for fpq_ledn_pattern (DIV=16, N_LED=8)
module tb_fpq_ledn_pattern;

  logic       clk_50mhz;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       clk_1hz;
  logic       step;
  logic [7:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  fpq_ledn_pattern #(.CLK_HZ(160), .TICK_HZ(10), .N_LED(8)) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .speed     (speed),
    .clk_1hz   (clk_1hz),
    .step      (step),
    .led       (led)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  logic [7:0] rot_r_tab [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] john_tab  [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
`ifdef LEDPAT_BOUNCE_EN
  logic [7:0] m10_tab   [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] post_rst_led = 8'h01;
`else
  logic [7:0] m10_tab   [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01,
                                 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] post_rst_led = 8'h02;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until step is seen or the budget runs out.
  task automatic wait_step(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_50mhz);
      cycles++;
    end while (!step && cycles < budget);
    if (!step) cycles = -1;
  endtask

  task automatic expect_step(input string tag, input int gap, input logic [7:0] exp_led);
    int c;
    wait_step(64, c);
    check_eq({tag, "_gap"}, c, gap);
    check_eq({tag, "_led"}, {24'h0, led}, {24'h0, exp_led});
  endtask

  initial begin
    int steps_seen;
    int toggles;
    int c;
    logic prev;

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    speed = 2'b00;
    repeat (3) @(negedge clk_50mhz);
    check_eq("rst_led", {24'h0, led}, 32'h01);
    check_eq("rst_step", {31'h0, step}, 32'h0);
    check_eq("rst_clk1hz", {31'h0, clk_1hz}, 32'h0);

    // Scenario 1: idle after reset, square wave free-running
    rst_n = 1'b1;
    steps_seen = 0;
    toggles = 0;
    prev = clk_1hz;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_50mhz);
      if (step) steps_seen++;
      if (clk_1hz != prev) begin
        toggles++;
        if (toggles == 1) check_eq("clk1hz_first_toggle", i, 8);
      end
      prev = clk_1hz;
    end
    check_eq("idle_steps", steps_seen, 0);
    check_eq("idle_toggles", toggles, 12);
    check_eq("idle_led", {24'h0, led}, 32'h01);

    // Scenario 2: rotate-left, 16 clocks per step
    start = 1'b1;
    for (int k = 0; k < 8; k++) expect_step("rotl", 16, 8'h02 << ((k + 1) % 8) >> 1 == 0 ? 8'h01 : (8'h01 << ((k + 1) % 8)));
    @(negedge clk_50mhz);
    check_eq("step_width", {31'h0, step}, 32'h0);
    wait_step(64, c);
    check_eq("rotl_resync", c, 15);
    check_eq("rotl_resync_led", {24'h0, led}, 32'h02);

    // Scenario 3: rotate-right seed then shifts, pause and resume from held count
    mode = 2'b01;
    expect_step("rotr_seed", 16, 8'h80);
    for (int k = 0; k < 3; k++) expect_step("rotr", 16, rot_r_tab[k]);
    repeat (5) @(negedge clk_50mhz);
    start = 1'b0;
    steps_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_50mhz);
      if (step) steps_seen++;
    end
    check_eq("pause_steps", steps_seen, 0);
    check_eq("pause_led", {24'h0, led}, 32'h10);
    start = 1'b1;
    expect_step("resume", 11, 8'h08);

    // Scenario 4: Johnson fill/clear
    mode = 2'b11;
    expect_step("john_seed", 16, 8'h00);
    for (int k = 0; k < 16; k++) expect_step("john", 16, john_tab[k]);

    // Scenario 5: speed raised while the count is already past the new limit
    repeat (9) @(negedge clk_50mhz);
    speed = 2'b11;
    expect_step("fast_first", 1, 8'h01);
    expect_step("fast_next", 2, 8'h03);
    expect_step("fast_third", 2, 8'h07);
    c = 0;
    prev = clk_1hz;
    while (clk_1hz == prev && c < 40) begin
      @(negedge clk_50mhz);
      c++;
    end
    prev = clk_1hz;
    c = 0;
    while (clk_1hz == prev && c < 40) begin
      @(negedge clk_50mhz);
      c++;
    end
    check_eq("fast_clk1hz_half", c, 8);
    wait_step(8, c);
    check_eq("fast_sync", {31'h0, c > 0 && c <= 2}, 32'h1);

    // Scenario 6: mode 10 (bounce or rotate-left depending on build), then reset mid-count
    speed = 2'b00;
    mode  = 2'b10;
    expect_step("m10_seed", 16, 8'h01);
    for (int k = 0; k < 15; k++) expect_step("m10", 16, m10_tab[k]);
    repeat (5) @(negedge clk_50mhz);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_led", {24'h0, led}, 32'h01);
    check_eq("midrst_step", {31'h0, step}, 32'h0);
    check_eq("midrst_clk1hz", {31'h0, clk_1hz}, 32'h0);
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    expect_step("post_rst", 16, post_rst_led);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
